afifo_rd_stream: RTL and testbench
==================================

Name: afifo_rd_stream

Overview:
- Read-side consumer for the asynchronous FIFO, living entirely in the read clock domain.
- Drives the FIFO pop interface (ren/empty/rdata) and turns it into a valid/ready stream toward downstream logic.
- Hides the FIFO's one-cycle read latency with a small credit-controlled output buffer, so a continuously ready sink sees one word per cycle.
- Also provides a synchronous flush that discards buffered and in-flight data.

Parameters:
- DSIZE, 8, data word width; must match the FIFO.
- OBUF_DEPTH, 2, output buffer entries; legal 2..8. A value of 2 gives full throughput.

Ports:
- rclk  input  1  read-domain clock
- rrst_n  input  1  asynchronous active-low reset
- empty  input  1  FIFO empty flag, rclk domain
- rdata  input  DSIZE  FIFO read data, valid exactly one cycle after the ren pulse
- ren  output  1  FIFO pop request
- flush  input  1  synchronous discard of buffered and in-flight words
- m_valid  output  1  stream word available
- m_ready  input  1  sink accepts the word
- m_data  output  DSIZE  stream data (head of buffer)
- obuf_cnt  output  $clog2(OBUF_DEPTH+1)  current buffer occupancy

Behaviour:
- Clocking and reset: single clock rclk. Reset is asynchronous and active-low on rrst_n.
- Reset values: m_valid=0, m_data=0, obuf_cnt=0, buffer pointers=0, inflight=0. ren=0 while rrst_n is low.
- Internal state: circular buffer of OBUF_DEPTH entries (wr_ptr, rd_ptr, cnt), plus a 1-bit inflight register (pop issued last cycle).
- Dequeue condition: deq = m_valid & m_ready.
- Pop condition: ren = !empty & !flush & ((cnt + inflight - deq) < OBUF_DEPTH).
  - ren depends combinationally on m_ready; this is intentional and is what sustains back-to-back throughput.
- Pop latency:
  - Pop in cycle N: inflight=1 in N+1.
  - rdata is sampled at the end of N+1 into buf[wr_ptr].
  - m_valid rises in N+2. Minimum empty-to-m_valid latency is 2 cycles.
- Stream outputs:
  - m_valid = (cnt != 0).
  - m_data = buf[rd_ptr], registered storage, no combinational path from rdata.
  - Once m_valid=1, m_data must stay stable until deq.
- Simultaneous capture and dequeue in one cycle: cnt is unchanged and both pointers advance.
- Pointer wrap: pointers wrap modulo OBUF_DEPTH; this must be correct for non-power-of-2 depths.
- Overflow: cnt never exceeds OBUF_DEPTH; the credit rule guarantees it. The bench must assert that no capture ever occurs at cnt==OBUF_DEPTH.
- Throughput: with m_ready held at 1 and the FIFO non-empty, ren=1 every cycle and one word is delivered per cycle.
- Flush:
  - In the flush cycle: ren=0 and m_valid is unaffected combinationally.
  - At the next edge: cnt=0, pointers=0, inflight=0. Any word returning on rdata that cycle is dropped.
  - A deq in the flush cycle still counts as delivered.
- Empty during inflight: a word already popped is still captured, even if empty asserts in the capture cycle.
- Reset mid-operation: all state clears immediately, including inflight; no word is emitted after reset release until a new pop completes.

Optional Feature:
- Macro: AFIFO_RD_STAT_EN.
- When defined, adds the following:
  - Output rd_words [15:0]: counts deq events, saturates at 16'hFFFF, cleared by reset only (not by flush).
  - Output flush_drop [7:0]: counts words discarded by flush (cnt plus inflight at the flush edge), saturating.
- When undefined, neither port nor any counter logic exists. Core behaviour is identical in both builds.

Test Plan:
- Basic pop: FIFO holds 0xA5, m_ready=1 -> ren high in cycle 0; m_valid=1 with m_data=0xA5 in cycle 2; ren low once empty=1.
- Streaming: 16 words 0x00..0x0F, m_ready=1 throughout -> ren asserted 16 consecutive cycles; m_data 0x00..0x0F in order, 16 consecutive valid cycles, no bubbles.
- Backpressure: m_ready=0 with FIFO non-empty -> exactly 2 pops then ren=0; obuf_cnt=2; m_data holds the first word. Release m_ready -> order preserved, no loss or duplicate.
- Random m_ready: 50% toggling over 200 words -> output sequence equals input sequence; obuf_cnt ≤ OBUF_DEPTH at all times. Repeat with OBUF_DEPTH=3 to exercise wrap.
- Flush: obuf_cnt=2 plus one pop in flight, assert flush one cycle -> next cycle m_valid=0 and obuf_cnt=0; the in-flight word is not emitted. With AFIFO_RD_STAT_EN, flush_drop=3.
- Reset: assert rrst_n low asynchronously while streaming -> m_valid and ren drop immediately (ren=0 while reset is held). After release, no stale word appears; the next FIFO word arrives 2 cycles after its pop. rd_words=0.

Source files
------------

// File: rtl/afifo_rd_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | afifo_rd_stream: async-FIFO read side to valid/ready stream adapter     |
// | with a credit-controlled output buffer that hides the read latency.     |
// | Optional build macro: AFIFO_RD_STAT_EN (rd_words / flush_drop counters) |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module afifo_rd_stream #(
  parameter int DSIZE      = 8,
  parameter int OBUF_DEPTH = 2
) (
  input  logic                            rclk,
  input  logic                            rrst_n,
  input  logic                            empty,
  input  logic [DSIZE-1:0]                rdata,
  output logic                            ren,
  input  logic                            flush,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DSIZE-1:0]                m_data,
  output logic [$clog2(OBUF_DEPTH+1)-1:0] obuf_cnt
`ifdef AFIFO_RD_STAT_EN
  ,
  output logic [15:0]                     rd_words,
  output logic [7:0]                      flush_drop
`endif
);

  localparam int            CW         = $clog2(OBUF_DEPTH + 1);
  localparam int            PW         = $clog2(OBUF_DEPTH);
  localparam logic [PW-1:0] C_PTR_LAST = PW'(OBUF_DEPTH - 1);
  localparam logic [CW:0]   C_DEPTH    = (CW + 1)'(OBUF_DEPTH);

  logic [DSIZE-1:0] buf_q [OBUF_DEPTH];
  logic [DSIZE-1:0] buf_d [OBUF_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             inflight_q, inflight_d;

  logic             w_deq;
  logic             w_cap;
  logic [CW:0]      w_occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_deq    = m_valid & m_ready;
  assign w_cap    = inflight_q & ~flush;
  // Occupancy after this edge if nothing new is popped: the credit test.
  assign w_occ    = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, w_deq};
  assign ren      = rrst_n & ~empty & ~flush & (w_occ < C_DEPTH);
  assign m_valid  = (cnt_q != '0);
  assign m_data   = buf_q[rd_ptr_q];
  assign obuf_cnt = cnt_q;

  always_comb begin
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    inflight_d = ren;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      inflight_d = 1'b0;
    end else begin
      if (w_cap) begin
        buf_d[wr_ptr_q] = rdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (w_deq) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({w_cap, w_deq})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef AFIFO_RD_STAT_EN
  logic [15:0] rd_words_q, rd_words_d;
  logic [7:0]  flush_drop_q, flush_drop_d;
  logic [8:0]  w_drop_sum;

  // A word dequeued in the flush cycle is delivered, so it is not counted as dropped.
  always_comb begin
    rd_words_d = rd_words_q;
    if (w_deq && (rd_words_q != 16'hFFFF)) begin
      rd_words_d = rd_words_q + 16'd1;
    end
    w_drop_sum   = {1'b0, flush_drop_q} + 9'(w_occ);
    flush_drop_d = flush_drop_q;
    if (flush) begin
      flush_drop_d = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_words_q   <= '0;
      flush_drop_q <= '0;
    end else begin
      rd_words_q   <= rd_words_d;
      flush_drop_q <= flush_drop_d;
    end
  end

  assign rd_words   = rd_words_q;
  assign flush_drop = flush_drop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_afifo_rd_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_afifo_rd_stream: scoreboard bench with a behavioural FIFO source     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_afifo_rd_stream;

  localparam int DSIZE = 8;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic             empty;
  logic [DSIZE-1:0] rdata;
  logic             ren;
  logic             flush;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic [CW-1:0]    obuf_cnt;
`ifdef AFIFO_RD_STAT_EN
  logic [15:0]      rd_words;
  logic [7:0]       flush_drop;
`endif

  logic [DSIZE-1:0] fmem [0:1023];
  int               fwr;
  int               frd;
  int               ndeliv;
  int               ndrop;
  int               n_cmp;
  int               n_fail;
  logic [DSIZE-1:0] exp_q [$];
  logic             infl;
  logic             hold_v = 1'b0;
  logic [DSIZE-1:0] hold_d;

  afifo_rd_stream #(.DSIZE(DSIZE), .OBUF_DEPTH(DEPTH)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .empty    (empty),
    .rdata    (rdata),
    .ren      (ren),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .obuf_cnt (obuf_cnt)
`ifdef AFIFO_RD_STAT_EN
    ,
    .rd_words   (rd_words),
    .flush_drop (flush_drop)
`endif
  );

  always #5 rclk = ~rclk;

  // Source FIFO: one-cycle read latency, junk on rdata when not popped.
  assign empty = (fwr == frd);
  always @(posedge rclk) begin
    if (ren) begin
      rdata <= fmem[frd[9:0]];
      frd   <= frd + 1;
    end else begin
      rdata <= 8'hEE;
    end
  end

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) infl <= 1'b0;
    else         infl <= ren;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic push(input logic [DSIZE-1:0] v);
    fmem[fwr[9:0]] = v;
    fwr++;
    exp_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge rclk);
    #2;
  endtask

  // Remove words the DUT legitimately discarded (popped, never delivered).
  task automatic discard(input int n_exp, input string name);
    int n;
    n = frd - ndeliv - ndrop;
    check(name, 32'(n), 32'(n_exp));
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    ndrop += n;
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    check({name, "_idle"}, 32'(m_valid), 32'd0);
  endtask

  // Monitor: scoreboard compare on every dequeue plus per-cycle invariants.
  always @(negedge rclk) begin
    if (rrst_n) begin
      check("occ_bound", 32'((obuf_cnt <= CW'(DEPTH)) &&
                             !(infl && !flush && (obuf_cnt == CW'(DEPTH)))), 32'd1);
      if (hold_v) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(hold_d));
      end
      hold_v <= m_valid && !m_ready && !flush;
      hold_d <= m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL deq_unexpected: got %0h, expected no word", m_data);
        end else begin
          check("deq_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        ndeliv++;
      end
    end else begin
      hold_v <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst_n  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;

    // Reset state, with a word already waiting in the FIFO.
    push(8'hA5);
    #2;
    check("rst_ren", 32'(ren), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_cnt", 32'(obuf_cnt), 32'd0);

    // Basic pop.
    @(posedge rclk);
    #2;
    rrst_n = 1'b1;
    #1;
    check("basic_ren_c0", 32'(ren), 32'd1);
    check("basic_valid_c0", 32'(m_valid), 32'd0);
    tick();
    check("basic_ren_c1", 32'(ren), 32'd0);
    check("basic_valid_c1", 32'(m_valid), 32'd0);
    tick();
    check("basic_valid_c2", 32'(m_valid), 32'd1);
    check("basic_data_c2", 32'(m_data), 32'hA5);
    check("basic_cnt_c2", 32'(obuf_cnt), 32'd1);
    tick();
    check("basic_valid_c3", 32'(m_valid), 32'd0);

    // Streaming, 16 words, sink always ready.
    for (int i = 0; i < 16; i++) push(8'(i));
    #1;
    for (int c = 0; c < 20; c++) begin
      check("stream_ren", 32'(ren), 32'(c < 16));
      check("stream_valid", 32'(m_valid), 32'(c >= 2 && c < 18));
      if (c >= 2 && c < 18) check("stream_data", 32'(m_data), 32'(c - 2));
      tick();
    end

    // Backpressure: exactly DEPTH pops, head word held.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    #1;
    for (int c = 0; c < 7; c++) begin
      check("bp_ren", 32'(ren), 32'(c < DEPTH));
      check("bp_cnt", 32'(obuf_cnt), (c < 2) ? 32'd0 : ((c - 1 < DEPTH) ? 32'(c - 1) : 32'(DEPTH)));
      if (c >= 2) check("bp_head", 32'(m_data), 32'h10);
      tick();
    end
    m_ready = 1'b1;
    drain(40, "bp_drain");

    // Random sink readiness with bursty arrivals.
    begin
      int pushed = 0;
      for (int c = 0; c < 1000 && pushed < 200; c++) begin
        if ($urandom_range(1, 0) == 1) begin
          push(8'(pushed * 7 + 3));
          pushed++;
        end
        m_ready = ($urandom_range(1, 0) == 1);
        tick();
      end
      check("rand_pushed", 32'(pushed), 32'd200);
    end
    m_ready = 1'b1;
    drain(300, "rand_drain");

    // Flush with two buffered words and one in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
    #1;
    tick();
    tick();
    tick();
    check("fl_pre_cnt", 32'(obuf_cnt), 32'd2);
    flush = 1'b1;
    #1;
    check("fl_ren", 32'(ren), 32'd0);
    check("fl_valid_kept", 32'(m_valid), 32'd1);
    tick();
    flush = 1'b0;
    #1;
    check("fl_valid", 32'(m_valid), 32'd0);
    check("fl_cnt", 32'(obuf_cnt), 32'd0);
    discard(3, "fl_dropped");
`ifdef AFIFO_RD_STAT_EN
    check("fl_stat_drop", 32'(flush_drop), 32'd3);
`endif
    m_ready = 1'b1;
    drain(40, "fl_drain");

    // Flush while streaming: ren blocked, the word dequeued that cycle is delivered.
    for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
    #1;
    tick();
    tick();
    check("fs_valid", 32'(m_valid), 32'd1);
    check("fs_data", 32'(m_data), 32'h50);
    flush = 1'b1;
    #1;
    check("fs_ren", 32'(ren), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("fs_cnt", 32'(obuf_cnt), 32'd0);
    discard(1, "fs_dropped");
    drain(40, "fs_drain");
`ifdef AFIFO_RD_STAT_EN
    check("fs_stat_drop", 32'(flush_drop), 32'd4);
    check("stat_rd_words", 32'(rd_words), 32'(ndeliv));
`endif

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
    #1;
    for (int c = 0; c < 5; c++) tick();
    rrst_n = 1'b0;
    #1;
    check("ar_valid", 32'(m_valid), 32'd0);
    check("ar_ren", 32'(ren), 32'd0);
    check("ar_cnt", 32'(obuf_cnt), 32'd0);
    check("ar_data", 32'(m_data), 32'd0);
`ifdef AFIFO_RD_STAT_EN
    check("ar_rd_words", 32'(rd_words), 32'd0);
`endif
    discard(2, "ar_dropped");
    tick();
    check("ar_ren_held", 32'(ren), 32'd0);
    tick();
    rrst_n = 1'b1;
    #1;
    check("ar_ren_r0", 32'(ren), 32'd1);
    check("ar_valid_r0", 32'(m_valid), 32'd0);
    tick();
    check("ar_valid_r1", 32'(m_valid), 32'd0);
    tick();
    check("ar_valid_r2", 32'(m_valid), 32'd1);
    check("ar_data_r2", 32'(m_data), 32'h45);
    drain(40, "ar_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
